sts_fault_latch: RTL and testbench
==================================

# sts_fault_latch

Captures the synchronized SPI-domain status flags in the AXI clock domain and turns them into sticky per-channel fault bits, a first-fault record (code, channel, timestamp), a level halt request and a one-cycle interrupt pulse. It sits directly downstream of the status synchronizer stage and feeds the AXI status register bank and the system shutdown logic.

## Interface
Parameters:
- `NUM_CH`, 8: channels per status vector; fixed at 8 for this board.
- `TS_WIDTH`, 32: timestamp counter width.

Ports:
- `aclk`  in  1  AXI clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  arm request, level.
- `clear`  in  1  clear sticky state, one-cycle pulse.
- `spi_off_stable`  in  1  SPI subsystem powered off.
- `over_thresh_stable`, `thresh_underflow_stable`, `thresh_overflow_stable`, `dac_buf_underflow_stable`, `adc_buf_overflow_stable`, `unexp_dac_trig_stable`, `unexp_adc_trig_stable`  in  8 each  synchronized per-channel flags.
- `sticky_<type>`  out  8 each  sticky copy of each of the seven inputs.
- `first_valid`  out  1  first-fault record valid.
- `first_code`  out  3  fault type, encoded 1..7 in port order above; 0 = none.
- `first_ch`  out  3  channel of first fault.
- `first_ts`  out  TS_WIDTH  timestamp of first fault.
- `fault`  out  1  halt request, level.
- `irq`  out  1  one-cycle pulse on entry to FAULTED.
- `state`  out  2  IDLE=0, ARMED=1, FAULTED=2.

## Operation
- Reset: all outputs 0, state IDLE, timestamp counter 0.
- IDLE: status inputs ignored; counter held at 0. Go ARMED when `enable`=1 and `spi_off_stable`=0.
- ARMED: counter increments each cycle, saturating at all-ones. Any set status bit -> FAULTED. `enable`=0 or `spi_off_stable`=1 -> IDLE, sticky bits retained, not a fault.
- FAULTED: `fault`=1; sticky bits continue OR-accumulating; first-fault record frozen; counter frozen. Leaves only on `clear`.
- First-fault selection among simultaneous bits: lowest code wins, then lowest channel.
- `clear` (any state): zeroes sticky bits, first-fault record, `fault`, counter; state -> IDLE. Clear wins over a fault in the same cycle; that cycle's status bits are discarded.
- Sticky bits update only in ARMED and FAULTED.

## Timing
- Inputs sampled directly (already registered upstream); no extra sync.
- Fault bit set in cycle N (ARMED) -> at N+1: sticky bit, `first_*`, `first_valid`, `fault`=1, `state`=FAULTED, `irq`=1 for exactly that cycle.
- `first_ts` = counter value in cycle N; first cycle of ARMED has counter 0.
- IDLE->ARMED: one cycle after condition true.
- `clear` in cycle N -> all cleared at N+1; if `enable` still 1, ARMED at N+2.
- Async reset mid-operation: immediate return to reset values; no `irq`.

## Configuration
- `STS_FAULT_TS_EN` defined: timestamp counter built; `first_ts` as above.
- Not defined: counter omitted; `first_ts` tied to 0; all other behaviour unchanged.

## Structure
- Shared header `sts_fault_defs.vh`: fault code localparams (`FC_NONE`=0 … `FC_UNEXP_ADC`=7), state encodings, `NUM_FAULT_TYPES`=7.
- Sub-module `sts_fault_prio_enc`: combinational 56-bit priority encoder -> {valid, code, channel}.

## Test plan
- Reset, `enable`=1, `spi_off_stable`=0 -> ARMED after 1 cycle; all sticky 0, `fault`=0.
- ARMED 10 cycles, pulse `thresh_overflow_stable`=8'h20 one cycle -> `first_code`=3, `first_ch`=5, `first_ts`=9, `irq` one pulse, `sticky_thresh_overflow`=8'h20 held after input drops.
- Simultaneous `over_thresh_stable`=8'h80 and `unexp_adc_trig_stable`=8'h01 -> `first_code`=1, `first_ch`=7; both sticky set.
- In FAULTED, assert `dac_buf_underflow_stable`=8'h03 -> sticky set, `first_*` unchanged, no second `irq`.
- `clear` coincident with `adc_buf_overflow_stable`=8'h01 -> all cleared, state IDLE then ARMED, fault re-captured two cycles later with `first_ts`=0.
- `spi_off_stable`=1 in ARMED -> IDLE, `fault`=0, `irq`=0; with macro undefined `first_ts` always 0.

Source files
------------

// File: rtl/sts_fault_latch_pkg.sv
// rtl/sts_fault_latch_pkg.sv - fault codes and state encodings for sts_fault_latch
package sts_fault_latch_pkg;

    localparam int NUM_FAULT_TYPES = 7;

    localparam logic [2:0] FC_NONE           = 3'd0;
    localparam logic [2:0] FC_OVER_THRESH    = 3'd1;
    localparam logic [2:0] FC_THRESH_UNDER   = 3'd2;
    localparam logic [2:0] FC_THRESH_OVER    = 3'd3;
    localparam logic [2:0] FC_DAC_BUF_UNDER  = 3'd4;
    localparam logic [2:0] FC_ADC_BUF_OVER   = 3'd5;
    localparam logic [2:0] FC_UNEXP_DAC      = 3'd6;
    localparam logic [2:0] FC_UNEXP_ADC      = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FAULTED = 2'd2
    } state_t;

endpackage

// File: rtl/sts_fault_prio_enc.sv
// rtl/sts_fault_prio_enc.sv - first-fault priority encoder: lowest code, then lowest channel
module sts_fault_prio_enc
    import sts_fault_latch_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_FAULT_TYPES*NUM_CH-1:0] i_vec,
    output logic                              o_valid,
    output logic [2:0]                        o_code,
    output logic [2:0]                        o_ch
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_code  = FC_NONE;
        o_ch    = 3'd0;
        for (int i = NUM_FAULT_TYPES*NUM_CH-1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_valid = 1'b1;
                o_code  = 3'(i / NUM_CH + 1);
                o_ch    = 3'(i % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/sts_fault_latch.sv
// rtl/sts_fault_latch.sv - sticky status faults, first-fault record, halt and irq
// Timestamp counter and first_ts are built only when STS_FAULT_TS_EN is defined.
module sts_fault_latch
    import sts_fault_latch_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                enable,
    input  logic                clear,
    input  logic                spi_off_stable,
    input  logic [NUM_CH-1:0]   over_thresh_stable,
    input  logic [NUM_CH-1:0]   thresh_underflow_stable,
    input  logic [NUM_CH-1:0]   thresh_overflow_stable,
    input  logic [NUM_CH-1:0]   dac_buf_underflow_stable,
    input  logic [NUM_CH-1:0]   adc_buf_overflow_stable,
    input  logic [NUM_CH-1:0]   unexp_dac_trig_stable,
    input  logic [NUM_CH-1:0]   unexp_adc_trig_stable,
    output logic [NUM_CH-1:0]   sticky_over_thresh,
    output logic [NUM_CH-1:0]   sticky_thresh_underflow,
    output logic [NUM_CH-1:0]   sticky_thresh_overflow,
    output logic [NUM_CH-1:0]   sticky_dac_buf_underflow,
    output logic [NUM_CH-1:0]   sticky_adc_buf_overflow,
    output logic [NUM_CH-1:0]   sticky_unexp_dac_trig,
    output logic [NUM_CH-1:0]   sticky_unexp_adc_trig,
    output logic                first_valid,
    output logic [2:0]          first_code,
    output logic [2:0]          first_ch,
    output logic [TS_WIDTH-1:0] first_ts,
    output logic                fault,
    output logic                irq,
    output logic [1:0]          state
);

    localparam int VW = NUM_FAULT_TYPES * NUM_CH;

    logic [VW-1:0] w_vec;
    logic          w_hit;
    logic [2:0]    w_code;
    logic [2:0]    w_ch;

    state_t        r_state;
    logic [VW-1:0] r_sticky;
    logic          r_first_valid;
    logic [2:0]    r_first_code;
    logic [2:0]    r_first_ch;
    logic          r_fault;
    logic          r_irq;

    // Fault code order: over_thresh occupies the lowest byte, unexp_adc the highest.
    assign w_vec = {unexp_adc_trig_stable, unexp_dac_trig_stable, adc_buf_overflow_stable,
                    dac_buf_underflow_stable, thresh_overflow_stable,
                    thresh_underflow_stable, over_thresh_stable};

    sts_fault_prio_enc #(.NUM_CH(NUM_CH)) u_prio_enc (
        .i_vec   (w_vec),
        .o_valid (w_hit),
        .o_code  (w_code),
        .o_ch    (w_ch)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= ST_IDLE;
            r_sticky      <= '0;
            r_first_valid <= 1'b0;
            r_first_code  <= FC_NONE;
            r_first_ch    <= 3'd0;
            r_fault       <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (clear) begin
                r_state       <= ST_IDLE;
                r_sticky      <= '0;
                r_first_valid <= 1'b0;
                r_first_code  <= FC_NONE;
                r_first_ch    <= 3'd0;
                r_fault       <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (enable && !spi_off_stable)
                            r_state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        r_sticky <= r_sticky | w_vec;
                        // A fault seen in the same cycle as a disarm still counts.
                        if (w_hit) begin
                            r_state       <= ST_FAULTED;
                            r_fault       <= 1'b1;
                            r_irq         <= 1'b1;
                            r_first_valid <= 1'b1;
                            r_first_code  <= w_code;
                            r_first_ch    <= w_ch;
                        end else if (!enable || spi_off_stable) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_FAULTED: begin
                        r_sticky <= r_sticky | w_vec;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef STS_FAULT_TS_EN
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic [TS_WIDTH-1:0] r_first_ts;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts_cnt   <= '0;
            r_first_ts <= '0;
        end else if (clear) begin
            r_ts_cnt   <= '0;
            r_first_ts <= '0;
        end else if (r_state == ST_IDLE) begin
            r_ts_cnt <= '0;
        end else if (r_state == ST_ARMED) begin
            if (w_hit)
                r_first_ts <= r_ts_cnt;
            if (r_ts_cnt != '1)
                r_ts_cnt <= r_ts_cnt + 1'b1;
        end
    end

    assign first_ts = r_first_ts;
`else
    assign first_ts = '0;
`endif

    assign sticky_over_thresh       = r_sticky[0*NUM_CH +: NUM_CH];
    assign sticky_thresh_underflow  = r_sticky[1*NUM_CH +: NUM_CH];
    assign sticky_thresh_overflow   = r_sticky[2*NUM_CH +: NUM_CH];
    assign sticky_dac_buf_underflow = r_sticky[3*NUM_CH +: NUM_CH];
    assign sticky_adc_buf_overflow  = r_sticky[4*NUM_CH +: NUM_CH];
    assign sticky_unexp_dac_trig    = r_sticky[5*NUM_CH +: NUM_CH];
    assign sticky_unexp_adc_trig    = r_sticky[6*NUM_CH +: NUM_CH];
    assign first_valid              = r_first_valid;
    assign first_code               = r_first_code;
    assign first_ch                 = r_first_ch;
    assign fault                    = r_fault;
    assign irq                      = r_irq;
    assign state                    = r_state;

endmodule

// File: tb/tb_sts_fault_latch.sv
// tb/tb_sts_fault_latch.sv - table-driven scoreboard bench for sts_fault_latch
module tb_sts_fault_latch;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        clear;
    logic        spi_off_stable;
    logic [55:0] flags;
    logic [7:0]  s_ot, s_tu, s_to, s_dbu, s_abo, s_udt, s_uat;
    logic        first_valid, fault, irq;
    logic [2:0]  first_code, first_ch;
    logic [31:0] first_ts;
    logic [1:0]  state;

    always #5 aclk = ~aclk;

    sts_fault_latch #(.NUM_CH(8), .TS_WIDTH(32)) dut (
        .aclk                     (aclk),
        .aresetn                  (aresetn),
        .enable                   (enable),
        .clear                    (clear),
        .spi_off_stable           (spi_off_stable),
        .over_thresh_stable       (flags[7:0]),
        .thresh_underflow_stable  (flags[15:8]),
        .thresh_overflow_stable   (flags[23:16]),
        .dac_buf_underflow_stable (flags[31:24]),
        .adc_buf_overflow_stable  (flags[39:32]),
        .unexp_dac_trig_stable    (flags[47:40]),
        .unexp_adc_trig_stable    (flags[55:48]),
        .sticky_over_thresh       (s_ot),
        .sticky_thresh_underflow  (s_tu),
        .sticky_thresh_overflow   (s_to),
        .sticky_dac_buf_underflow (s_dbu),
        .sticky_adc_buf_overflow  (s_abo),
        .sticky_unexp_dac_trig    (s_udt),
        .sticky_unexp_adc_trig    (s_uat),
        .first_valid              (first_valid),
        .first_code               (first_code),
        .first_ch                 (first_ch),
        .first_ts                 (first_ts),
        .fault                    (fault),
        .irq                      (irq),
        .state                    (state)
    );

    typedef struct {
        logic        en, off, clr;
        logic [55:0] vec;
        logic [1:0]  st;
        logic        flt, irq, fv;
        logic [2:0]  code, ch;
        logic [31:0] ts;
        logic [55:0] sticky;
    } row_t;

    row_t tbl[$];
    row_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [55:0] fv(input logic [7:0] ot, tu, to_, dbu, abo, udt, uat);
        return {uat, udt, abo, dbu, to_, tu, ot};
    endfunction

    function automatic logic [31:0] ets(input logic [31:0] v);
`ifdef STS_FAULT_TS_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    function automatic row_t mk(input logic en, off, clr, input logic [55:0] vec,
                                input logic [1:0] st, input logic flt, irq_, fvld,
                                input logic [2:0] code, ch, input logic [31:0] ts,
                                input logic [55:0] sticky);
        row_t r;
        r.en = en; r.off = off; r.clr = clr; r.vec = vec;
        r.st = st; r.flt = flt; r.irq = irq_; r.fv = fvld;
        r.code = code; r.ch = ch; r.ts = ets(ts); r.sticky = sticky;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input row_t e);
        check({tag, " state"},  64'(state), 64'(e.st));
        check({tag, " fault"},  64'(fault), 64'(e.flt));
        check({tag, " irq"},    64'(irq), 64'(e.irq));
        check({tag, " fvalid"}, 64'(first_valid), 64'(e.fv));
        check({tag, " code"},   64'(first_code), 64'(e.code));
        check({tag, " ch"},     64'(first_ch), 64'(e.ch));
        check({tag, " ts"},     64'(first_ts), 64'(e.ts));
        check({tag, " sticky"}, 64'({s_uat, s_udt, s_abo, s_dbu, s_to, s_tu, s_ot}), 64'(e.sticky));
    endtask

    initial begin
        row_t e;
        logic [55:0] z, st_to, st_to_dbu, abo1, multi, tu0c;
        z         = '0;
        st_to     = fv(0, 0, 8'h20, 0, 0, 0, 0);
        st_to_dbu = fv(0, 0, 8'h20, 8'h03, 0, 0, 0);
        abo1      = fv(0, 0, 0, 0, 8'h01, 0, 0);
        multi     = fv(8'h80, 0, 0, 0, 0, 0, 8'h01);
        tu0c      = fv(0, 8'h0C, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, st_to, 2, 1, 1, 1, 3, 5, 9, st_to));
        tbl.push_back(mk(1, 0, 0, z, 2, 1, 0, 1, 3, 5, 9, st_to));
        tbl.push_back(mk(1, 0, 0, fv(0, 0, 0, 8'h03, 0, 0, 0), 2, 1, 0, 1, 3, 5, 9, st_to_dbu));
        tbl.push_back(mk(1, 0, 1, abo1, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, abo1, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, abo1, 2, 1, 1, 1, 5, 0, 0, abo1));
        tbl.push_back(mk(1, 0, 1, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 1, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 1, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, multi, 2, 1, 1, 1, 1, 7, 1, multi));
        tbl.push_back(mk(0, 0, 0, z, 2, 1, 0, 1, 1, 7, 1, multi));
        tbl.push_back(mk(0, 0, 1, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(0, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(0, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));
        tbl.push_back(mk(1, 0, 0, tu0c, 2, 1, 1, 1, 2, 2, 0, tu0c));

        aresetn = 1'b0; enable = 1'b0; clear = 1'b0; spi_off_stable = 1'b0; flags = '0;
        repeat (2) @(posedge aclk);
        #1;
        check_row("reset", mk(0, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en; spi_off_stable = tbl[i].off;
            clear  = tbl[i].clr; flags = tbl[i].vec;
            exp_q.push_back(tbl[i]);
            @(posedge aclk);
            #1;
            e = exp_q.pop_front();
            check_row($sformatf("row%0d", i), e);
        end

        // Async reset from FAULTED: outputs drop before the next clock edge.
        enable = 1'b1; clear = 1'b0; spi_off_stable = 1'b0; flags = '0;
        #3;
        aresetn = 1'b0;
        #1;
        check_row("async_rst", mk(0, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        @(posedge aclk);
        #1;
        check_row("rst_hold", mk(0, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, z));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_row("rst_rearm", mk(0, 0, 0, z, 1, 0, 0, 0, 0, 0, 0, z));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
